multi_channel_traffic_generator: RTL

MULTI_CHANNEL_TRAFFIC_GENERATOR -- requirements
Module: multi_channel_traffic_generator

---
 rtl/multi_channel_traffic_generator.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_channel_traffic_generator.sv
// Multi-channel packet traffic generator feeding a PIFO push port.
// Per-channel LFSR-paced requests, round-robin grant, one registered output slot.

module linear_feedback_shift_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             advance,
  output logic [WIDTH-1:0] value
);

  // Galois right-shift feedback masks for maximal-length polynomials.
  function automatic logic [WIDTH-1:0] tap_mask();
    logic [WIDTH-1:0] m;
    case (WIDTH)
      2:       m = WIDTH'(32'h0003);
      3:       m = WIDTH'(32'h0006);
      4:       m = WIDTH'(32'h000C);
      5:       m = WIDTH'(32'h0014);
      6:       m = WIDTH'(32'h0030);
      7:       m = WIDTH'(32'h0060);
      8:       m = WIDTH'(32'h00B8);
      9:       m = WIDTH'(32'h0110);
      10:      m = WIDTH'(32'h0240);
      11:      m = WIDTH'(32'h0500);
      12:      m = WIDTH'(32'h0829);
      13:      m = WIDTH'(32'h100D);
      14:      m = WIDTH'(32'h2015);
      15:      m = WIDTH'(32'h6000);
      16:      m = WIDTH'(32'hB400);
      default: begin
        m = '0;
        m[WIDTH-1] = 1'b1;
        m[0] = 1'b1;
      end
    endcase
    return m;
  endfunction

  localparam logic [WIDTH-1:0] TAPS = tap_mask();

  logic [WIDTH-1:0] value_nxt;

  assign value_nxt = value[0] ? ((value >> 1) ^ TAPS) : (value >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= WIDTH'(1);
    end else if (load) begin
      value <= seed;
    end else if (advance) begin
      value <= value_nxt;
    end
  end

endmodule

module multi_channel_traffic_generator #(
  parameter  int NUM_CH = 4,
  parameter  int SEQ_W  = 8,
  parameter  int PRIO_W = 16,
  parameter  int RATE_W = 8,
  parameter  int CNT_W  = 16,
  localparam int CH_W   = $clog2(NUM_CH),
  localparam int PTR_W  = CH_W + SEQ_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i__start,
  input  logic                    i__abort,
  input  logic                    i__enable,
  input  logic [NUM_CH*RATE_W-1:0] i__injrate,
  input  logic [NUM_CH*CNT_W-1:0] i__total_packets,
  input  logic [1:0]              i__prio_mode,
  input  logic [PRIO_W-1:0]       i__fixed_priority,
  input  logic [PRIO_W-1:0]       i__seed,
  input  logic                    i__ready,
  output logic                    o__valid,
  output logic [PTR_W-1:0]        o__packet_pointer,
  output logic [PRIO_W-1:0]       o__packet_priority,
  output logic [CH_W-1:0]         o__channel,
  output logic                    o__busy,
  output logic                    o__done,
  output logic [NUM_CH*CNT_W-1:0] o__sent_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t state, state_nxt;

  logic [CNT_W-1:0]  sent_cnt [NUM_CH];
  logic [SEQ_W-1:0]  seq      [NUM_CH];
  logic [PRIO_W-1:0] asc_prio [NUM_CH];
  logic [RATE_W-1:0] rate_val [NUM_CH];
  logic [PRIO_W-1:0] prio_val [NUM_CH];
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] exhausted;
  logic [CH_W-1:0]   last_gnt;

  logic              start_run;
  logic              slot_free;
  logic              gnt_any_p0;
  logic              gnt_fire_p0;
  logic [CH_W-1:0]   gnt_ch_p0;
  logic [CH_W-1:0]   scan_idx;
  logic [PRIO_W-1:0] gnt_prio_p0;

  logic              vld_p1;
  logic [PTR_W-1:0]  ptr_p1;
  logic [PRIO_W-1:0] prio_p1;
  logic [CH_W-1:0]   ch_p1;

  assign start_run = ((state == S_IDLE) || (state == S_DONE)) && i__start && !i__abort;
  assign slot_free = !vld_p1 || i__ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [RATE_W-1:0] rate_c;
    logic [CNT_W-1:0]  total_c;
    logic [PRIO_W-1:0] seed_c;
    logic [RATE_W-1:0] rate_seed_raw;
    logic [RATE_W-1:0] rate_seed;
    logic [PRIO_W-1:0] prio_seed;

    assign rate_c        = i__injrate[c*RATE_W +: RATE_W];
    assign total_c       = i__total_packets[c*CNT_W +: CNT_W];
    assign seed_c        = i__seed ^ PRIO_W'(c);
    assign rate_seed_raw = RATE_W'(seed_c);
    // A zero seed would lock the LFSR, so it is forced to 1.
    assign rate_seed     = (rate_seed_raw == '0) ? RATE_W'(1) : rate_seed_raw;
    assign prio_seed     = (seed_c == '0) ? PRIO_W'(1) : seed_c;

    assign exhausted[c] = (sent_cnt[c] >= total_c);
    assign req[c]       = (state == S_RUN) && i__enable && !exhausted[c] &&
                          ((rate_val[c] < rate_c) || (&rate_c));
    assign o__sent_count[c*CNT_W +: CNT_W] = sent_cnt[c];

    linear_feedback_shift_register #(.WIDTH(RATE_W)) u_rate_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load    (start_run),
      .seed    (rate_seed),
      .advance ((state == S_RUN) && i__enable),
      .value   (rate_val[c])
    );

    linear_feedback_shift_register #(.WIDTH(PRIO_W)) u_prio_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load    (start_run),
      .seed    (prio_seed),
      .advance (gnt_fire_p0 && (gnt_ch_p0 == CH_W'(c))),
      .value   (prio_val[c])
    );
  end

  // Round-robin scan: walking downward leaves the nearest requester after last_gnt.
  always_comb begin
    gnt_any_p0 = 1'b0;
    gnt_ch_p0  = '0;
    scan_idx   = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      scan_idx = last_gnt + CH_W'(i);
      if (req[scan_idx]) begin
        gnt_any_p0 = 1'b1;
        gnt_ch_p0  = scan_idx;
      end
    end
  end

  assign gnt_fire_p0 = gnt_any_p0 && slot_free && !i__abort;

  always_comb begin
    case (i__prio_mode)
      2'd1:    gnt_prio_p0 = asc_prio[gnt_ch_p0];
      2'd2:    gnt_prio_p0 = i__fixed_priority;
      default: gnt_prio_p0 = prio_val[gnt_ch_p0];
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i__start) state_nxt = S_RUN;
      S_RUN:   if (&exhausted) state_nxt = S_DRAIN;
      S_DRAIN: if (!vld_p1 || i__ready) state_nxt = S_DONE;
      S_DONE:  if (i__start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
    if (i__abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start_run) begin
      last_gnt <= CH_W'(NUM_CH - 1);
      for (int c = 0; c < NUM_CH; c++) begin
        sent_cnt[c] <= '0;
        seq[c]      <= '0;
        asc_prio[c] <= '0;
      end
    end else if (gnt_fire_p0) begin
      last_gnt <= gnt_ch_p0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (gnt_ch_p0 == CH_W'(c)) begin
          sent_cnt[c] <= sat_inc(sent_cnt[c]);
          seq[c]      <= seq[c] + SEQ_W'(1);
          asc_prio[c] <= asc_prio[c] + PRIO_W'(1);
        end
      end
    end
  end

  // Output slot: loaded on grant, held until accepted, dropped only on abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      ptr_p1  <= '0;
      prio_p1 <= '0;
      ch_p1   <= '0;
    end else if (i__abort) begin
      vld_p1 <= 1'b0;
    end else if (gnt_fire_p0) begin
      vld_p1  <= 1'b1;
      ptr_p1  <= {gnt_ch_p0, seq[gnt_ch_p0]};
      prio_p1 <= gnt_prio_p0;
      ch_p1   <= gnt_ch_p0;
    end else if (i__ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign o__valid           = vld_p1;
  assign o__packet_pointer  = ptr_p1;
  assign o__packet_priority = prio_p1;
  assign o__channel         = ch_p1;
  assign o__busy            = (state == S_RUN) || (state == S_DRAIN);
  assign o__done            = (state == S_DONE);

endmodule
